// File: rtl/segrw_arb2.sv
// -----------------------------------------------------------------------------
// segrw_arb2 : two-client arbiter in front of one segment read/write operator.
//
// Each client offers addr/dataW/write token streams and receives dataR tokens.
// One request per cycle is forwarded to the segment with zero latency. A tag
// FIFO remembers which client issued each outstanding request, so returned
// dataR tokens are routed back in order. Client eos tokens are absorbed and
// answered with a per-client dataR eos once that client's responses are
// drained; when both clients are closed a single eos goes to the segment.
//
// Handshake: every stream uses (d, v, e, b). A token moves in a cycle where
// v=1 and b=0. b=1 means stall. e marks the end-of-stream token.
//
// Build option: define SEGARB_FIXED_PRIO_EN to give client 0 fixed priority
// when both clients are eligible; otherwise grants alternate round-robin.
//
// Ports:
//   clock, reset                 clock, asynchronous active-low reset
//   cK_addr_*  (K=0,1)           client address stream (in d/v/e, out b)
//   cK_dataW_*                   client write-data stream
//   cK_write_*                   client write-enable stream
//   cK_dataR_*                   response stream to client (out d/v/e, in b)
//   seg_addr_*/dataW_*/write_*   request streams to the segment
//   seg_dataR_*                  response stream from the segment
//   err                          sticky protocol-error flag
//   state_dbg                    FSM state (0=RUN, 1=SEG_EOS, 2=DONE)
// -----------------------------------------------------------------------------
module segrw_arb2 #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clock,
  input  logic              reset,
  // client 0
  input  logic [ADDR_W-1:0] c0_addr_d,
  input  logic              c0_addr_v,
  input  logic              c0_addr_e,
  output logic              c0_addr_b,
  input  logic [DATA_W-1:0] c0_dataW_d,
  input  logic              c0_dataW_v,
  input  logic              c0_dataW_e,
  output logic              c0_dataW_b,
  input  logic              c0_write_d,
  input  logic              c0_write_v,
  input  logic              c0_write_e,
  output logic              c0_write_b,
  output logic [DATA_W-1:0] c0_dataR_d,
  output logic              c0_dataR_v,
  output logic              c0_dataR_e,
  input  logic              c0_dataR_b,
  // client 1
  input  logic [ADDR_W-1:0] c1_addr_d,
  input  logic              c1_addr_v,
  input  logic              c1_addr_e,
  output logic              c1_addr_b,
  input  logic [DATA_W-1:0] c1_dataW_d,
  input  logic              c1_dataW_v,
  input  logic              c1_dataW_e,
  output logic              c1_dataW_b,
  input  logic              c1_write_d,
  input  logic              c1_write_v,
  input  logic              c1_write_e,
  output logic              c1_write_b,
  output logic [DATA_W-1:0] c1_dataR_d,
  output logic              c1_dataR_v,
  output logic              c1_dataR_e,
  input  logic              c1_dataR_b,
  // segment
  output logic [ADDR_W-1:0] seg_addr_d,
  output logic              seg_addr_v,
  output logic              seg_addr_e,
  input  logic              seg_addr_b,
  output logic [DATA_W-1:0] seg_dataW_d,
  output logic              seg_dataW_v,
  output logic              seg_dataW_e,
  input  logic              seg_dataW_b,
  output logic              seg_write_d,
  output logic              seg_write_v,
  output logic              seg_write_e,
  input  logic              seg_write_b,
  input  logic [DATA_W-1:0] seg_dataR_d,
  input  logic              seg_dataR_v,
  input  logic              seg_dataR_e,
  output logic              seg_dataR_b,
  // status
  output logic              err,
  output logic [1:0]        state_dbg
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_SEG_EOS = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t state, state_nxt;

  // tag FIFO: one bit per outstanding request, 0 = client 0, 1 = client 1
  logic             tag_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] out_cnt [2];
  logic [1:0]       done, eos_sent;
`ifndef SEGARB_FIXED_PRIO_EN
  logic             rr_ptr;
`endif

  // per-client stream summaries
  logic [1:0] all_v, any_e, all_e, dataR_b_in;
  logic       seg_rdy, fifo_full, fifo_empty, head;

  // combinational decisions
  logic       push, pop, stray, grant_id;
  logic [1:0] elig, eos_in, eos_mix, eos_fire, client_b, r_v, r_e;

  assign all_v[0] = c0_addr_v & c0_dataW_v & c0_write_v;
  assign all_v[1] = c1_addr_v & c1_dataW_v & c1_write_v;
  assign any_e[0] = c0_addr_e | c0_dataW_e | c0_write_e;
  assign any_e[1] = c1_addr_e | c1_dataW_e | c1_write_e;
  assign all_e[0] = c0_addr_e & c0_dataW_e & c0_write_e;
  assign all_e[1] = c1_addr_e & c1_dataW_e & c1_write_e;
  assign dataR_b_in = {c1_dataR_b, c0_dataR_b};

  assign seg_rdy    = ~seg_addr_b & ~seg_dataW_b & ~seg_write_b;
  // full is judged on the registered count, so a same-cycle pop never frees a slot
  assign fifo_full  = (count == CNT_W'(DEPTH));
  assign fifo_empty = (count == '0);
  assign head       = tag_mem[rd_ptr];

  assign state_dbg  = state;

  always_comb begin
    state_nxt   = state;
    push        = 1'b0;
    pop         = 1'b0;
    stray       = 1'b0;
    grant_id    = 1'b0;
    elig        = 2'b00;
    eos_in      = 2'b00;
    eos_mix     = 2'b00;
    eos_fire    = 2'b00;
    client_b    = 2'b11;
    r_v         = 2'b00;
    r_e         = 2'b00;
    seg_addr_d  = '0;
    seg_addr_v  = 1'b0;
    seg_addr_e  = 1'b0;
    seg_dataW_d = '0;
    seg_dataW_v = 1'b0;
    seg_dataW_e = 1'b0;
    seg_write_d = 1'b0;
    seg_write_v = 1'b0;
    seg_write_e = 1'b0;
    seg_dataR_b = 1'b1;

    // nothing is accepted or offered while reset is held
    if (reset) begin
      case (state)
        ST_RUN: begin
          for (int k = 0; k < 2; k++) begin
            eos_in[k]  = all_v[k] & any_e[k] & ~done[k];
            eos_mix[k] = eos_in[k] & ~all_e[k];
            elig[k]    = all_v[k] & ~any_e[k] & ~done[k] & ~fifo_full & seg_rdy;
          end

`ifdef SEGARB_FIXED_PRIO_EN
          grant_id = ~elig[0];
`else
          grant_id = (elig[0] & elig[1]) ? rr_ptr : elig[1];
`endif
          push = |elig;

          if (push) begin
            seg_addr_v  = 1'b1;
            seg_dataW_v = 1'b1;
            seg_write_v = 1'b1;
            seg_addr_d  = grant_id ? c1_addr_d  : c0_addr_d;
            seg_dataW_d = grant_id ? c1_dataW_d : c0_dataW_d;
            seg_write_d = grant_id ? c1_write_d : c0_write_d;
            client_b[grant_id] = 1'b0;
          end

          // eos tokens are swallowed without needing the segment or FIFO space
          for (int k = 0; k < 2; k++) begin
            if (eos_in[k]) client_b[k] = 1'b0;
          end

          // a client's eos goes out only once it has no tags left in the FIFO,
          // so it can never collide with a routed response for the same client
          for (int k = 0; k < 2; k++) begin
            if (done[k] && out_cnt[k] == '0 && !eos_sent[k]) begin
              r_v[k]      = 1'b1;
              r_e[k]      = 1'b1;
              eos_fire[k] = ~dataR_b_in[k];
            end
          end

          if (eos_sent == 2'b11 && fifo_empty) state_nxt = ST_SEG_EOS;
        end

        ST_SEG_EOS: begin
          seg_addr_v  = 1'b1;
          seg_addr_e  = 1'b1;
          seg_dataW_v = 1'b1;
          seg_dataW_e = 1'b1;
          seg_write_v = 1'b1;
          seg_write_e = 1'b1;
          if (seg_rdy) state_nxt = ST_DONE;
        end

        ST_DONE: begin
          // absorb anything the segment still sends, including its eos
          seg_dataR_b = 1'b0;
        end

        default: state_nxt = ST_RUN;
      endcase

      // response routing is live until the segment has been closed
      if ((state == ST_RUN || state == ST_SEG_EOS) && seg_dataR_v && !seg_dataR_e) begin
        if (!fifo_empty) begin
          r_v[head]   = 1'b1;
          seg_dataR_b = dataR_b_in[head];
          pop         = ~dataR_b_in[head];
        end else begin
          // response with no matching request: drop it and flag the error
          seg_dataR_b = 1'b0;
          stray       = 1'b1;
        end
      end
    end

    c0_addr_b  = client_b[0];
    c0_dataW_b = client_b[0];
    c0_write_b = client_b[0];
    c1_addr_b  = client_b[1];
    c1_dataW_b = client_b[1];
    c1_write_b = client_b[1];
    c0_dataR_d = seg_dataR_d;
    c1_dataR_d = seg_dataR_d;
    c0_dataR_v = r_v[0];
    c0_dataR_e = r_e[0];
    c1_dataR_v = r_v[1];
    c1_dataR_e = r_e[1];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_RUN;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      out_cnt[0] <= '0;
      out_cnt[1] <= '0;
      done       <= 2'b00;
      eos_sent   <= 2'b00;
      err        <= 1'b0;
`ifndef SEGARB_FIXED_PRIO_EN
      rr_ptr     <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      for (int k = 0; k < 2; k++) begin
        case ({push && (grant_id == k[0]), pop && (head == k[0])})
          2'b10:   out_cnt[k] <= out_cnt[k] + CNT_W'(1);
          2'b01:   out_cnt[k] <= out_cnt[k] - CNT_W'(1);
          default: out_cnt[k] <= out_cnt[k];
        endcase
      end
      done     <= done | eos_in;
      eos_sent <= eos_sent | eos_fire;
      if (stray || (|eos_mix)) err <= 1'b1;
`ifndef SEGARB_FIXED_PRIO_EN
      // the client just served drops to second place
      if (push) rr_ptr <= ~grant_id;
`endif
    end
  end

  // tag storage needs no reset: count/pointers define which entries are live
  always_ff @(posedge clock) begin
    if (push) tag_mem[wr_ptr] <= grant_id;
  end

endmodule
